// File: rtl/vld_getbits_pkg.sv
// vld_pkg: shared constants for the vld_getbits bit-extraction stage.
//   GB_WINDOW    bit window width (MSB-aligned)
//   GB_LOOKAHEAD width of the getbits lookahead / max advance per cycle
//   GB_WORD      fifo word width
//   GB_FILL_W    width of the fill counter (0..64)
package vld_pkg;
  localparam int GB_WINDOW    = 64;
  localparam int GB_LOOKAHEAD = 24;
  localparam int GB_WORD      = 32;
  localparam int GB_FILL_W    = 7;
  localparam int GB_ADV_W     = 5;
endpackage

// File: rtl/vld_getbits_if.sv
// vld_getbits_if: fifo-side and decoder-side signals of vld_getbits.
//   master: the getbits stage (drives fifo_rd_en, getbits, getbits_valid)
//   slave : the environment (fifo + variable-length decoder)
interface vld_getbits_if;
  logic [vld_pkg::GB_WORD-1:0]      fifo_dout;
  logic                             fifo_empty;
  logic                             fifo_valid;
  logic                             fifo_rd_en;
  logic                             flush;
  logic [vld_pkg::GB_ADV_W-1:0]     advance;
  logic                             align;
  logic [vld_pkg::GB_LOOKAHEAD-1:0] getbits;
  logic                             getbits_valid;

  modport master (
    input  fifo_dout, fifo_empty, fifo_valid, flush, advance, align,
    output fifo_rd_en, getbits, getbits_valid
  );

  modport slave (
    output fifo_dout, fifo_empty, fifo_valid, flush, advance, align,
    input  fifo_rd_en, getbits, getbits_valid
  );
endinterface

// File: rtl/vld_getbits_shift.sv
// vld_getbits_shift: combinational left barrel shift of the bit window by
// the consumed amount, merged with an optional new fifo word placed just
// below the remaining valid bits.
//   win      current window (MSB-aligned)
//   amt      bits consumed this cycle
//   ins_en   insert ins_word
//   ins_word fifo word to append
//   ins_ofs  fill after consumption; word lands at [63-ins_ofs -: 32]
//   win_nxt  resulting window
module vld_getbits_shift
  import vld_pkg::*;
(
  input  logic [GB_WINDOW-1:0] win,
  input  logic [GB_ADV_W-1:0]  amt,
  input  logic                 ins_en,
  input  logic [GB_WORD-1:0]   ins_word,
  input  logic [GB_FILL_W-1:0] ins_ofs,
  output logic [GB_WINDOW-1:0] win_nxt
);
  logic [GB_WINDOW-1:0] ins_vec;

  // Bits below fill are always zero, so the new word can simply be OR-ed in.
  assign ins_vec = ins_en ? ({ins_word, {(GB_WINDOW-GB_WORD){1'b0}}} >> ins_ofs)
                          : '0;
  assign win_nxt = (win << amt) | ins_vec;
endmodule

// File: rtl/vld_getbits.sv
// vld_getbits: bit-extraction stage between the video-buffer fifo
// (32-bit words, data one cycle after rd_en) and the VLD.  Holds a 64-bit
// MSB-aligned window and presents the next 24 unconsumed bits.
//   clk, rst       clock, synchronous active-low reset
//   bus.fifo_*     fifo read interface (rd_en out, dout/empty/valid in)
//   bus.flush      drop window contents and any in-flight word
//   bus.advance    bits to consume (0..24, larger values clamp to 24)
//   bus.align      consume to next byte boundary (overrides advance)
//   bus.getbits    next 24 bits, MSB oldest; bus.getbits_valid when fill>=24
// Optional macro VLD_GETBITS_ASSERT_EN enables simulation-only protocol
// checks that report misuse with $display.
module vld_getbits
  import vld_pkg::*;
#(
  parameter int FIFO_WIDTH = 32,
  parameter int LOOKAHEAD  = 24
) (
  input  logic          clk,
  input  logic          rst,
  vld_getbits_if.master bus
);
  generate
    if (FIFO_WIDTH != GB_WORD) begin : g_bad_width
      $error("vld_getbits: FIFO_WIDTH must be 32");
    end
    if (LOOKAHEAD != GB_LOOKAHEAD) begin : g_bad_look
      $error("vld_getbits: LOOKAHEAD must be 24");
    end
  endgenerate

  logic [GB_WINDOW-1:0] window, win_nxt;
  logic [GB_FILL_W-1:0] fill, fill_c, fill_nxt;
  logic                 pend;
  logic [2:0]           bofs;
  logic [GB_ADV_W-1:0]  amt;
  logic                 gb_valid;
  logic                 ins;
  logic                 rd_en;

  assign gb_valid = (fill >= GB_FILL_W'(GB_LOOKAHEAD));

  // Consume amount; nothing is consumed while the lookahead is not full.
  always_comb begin
    amt = '0;
    if (gb_valid) begin
      if (bus.align)
        amt = {2'b00, 3'd0 - bofs};
      else if (int'(bus.advance) > LOOKAHEAD)
        amt = GB_ADV_W'(LOOKAHEAD);
      else
        amt = bus.advance;
    end
  end

  assign fill_c   = fill - {2'b00, amt};
  // A valid without an outstanding read (e.g. after reset/flush) is dropped.
  assign ins      = bus.fifo_valid && pend;
  assign fill_nxt = ins ? fill_c + GB_FILL_W'(GB_WORD) : fill_c;

  // Only read when the word is guaranteed to fit once it lands, counting a
  // read already in flight.
  assign rd_en = !bus.fifo_empty && rst && !bus.flush &&
                 (({1'b0, fill} + (pend ? 8'd32 : 8'd0)) <= 8'd32);

  vld_getbits_shift u_shift (
    .win      (window),
    .amt      (amt),
    .ins_en   (ins),
    .ins_word (bus.fifo_dout),
    .ins_ofs  (fill_c),
    .win_nxt  (win_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst || bus.flush) begin
      window <= '0;
      fill   <= '0;
      pend   <= 1'b0;
      bofs   <= '0;
    end else begin
      window <= win_nxt;
      fill   <= fill_nxt;
      pend   <= rd_en;
      bofs   <= bofs + amt[2:0];
    end
  end

  assign bus.fifo_rd_en    = rd_en;
  assign bus.getbits       = window[GB_WINDOW-1 -: GB_LOOKAHEAD];
  assign bus.getbits_valid = gb_valid;

`ifdef VLD_GETBITS_ASSERT_EN
  always_ff @(posedge clk) begin
    if (rst && !bus.flush) begin
      if (int'(bus.advance) > LOOKAHEAD)
        $display("ERROR %m @%0t: advance %0d > %0d", $time, bus.advance, LOOKAHEAD);
      if (!gb_valid && (bus.advance != '0 || bus.align))
        $display("ERROR %m @%0t: advance/align while getbits_valid=0", $time);
      if (bus.fifo_valid && !pend)
        $display("ERROR %m @%0t: fifo_valid without outstanding read", $time);
      if (ins && fill_c > GB_FILL_W'(GB_WORD))
        $display("ERROR %m @%0t: fill would exceed %0d", $time, GB_WINDOW);
    end
  end
`endif
endmodule

// File: tb/tb_vld_getbits.sv
// tb_vld_getbits: directed + random bench.  Fifo words are queued as
// stimulus; delivered words are pushed bit-by-bit into a reference
// bitstream queue that is consumed per the decoder controls and compared
// against getbits every cycle.
module tb_vld_getbits;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vld_getbits_if gbus ();

  vld_getbits dut (
    .clk (clk),
    .rst (rst),
    .bus (gbus)
  );

  int total = 0;
  int bad   = 0;

  bit          mq[$];    // reference bits held in the window, oldest first
  int unsigned fq[$];    // words waiting in the emulated fifo
  int          mbofs = 0;
  bit          mpend = 1'b0;
  bit          stray = 1'b0;
  bit          last_rd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_gb();
    logic [23:0] v = '0;
    for (int i = 0; i < 24; i++)
      v[23-i] = (i < mq.size()) ? mq[i] : 1'b0;
    return v;
  endfunction

  task automatic step(input int adv, input bit aln, input bit fl, input bit r = 1'b1);
    bit exp_rd, mvalid, rd;
    int amt;
    gbus.advance    = 5'(adv);
    gbus.align      = aln;
    gbus.flush      = fl;
    rst             = r;
    gbus.fifo_empty = (fq.size() == 0);
    #1;
    mvalid = (mq.size() >= 24);
    exp_rd = (fq.size() != 0) && r && !fl && ((mq.size() + (mpend ? 32 : 0)) <= 32);
    rd     = gbus.fifo_rd_en;
    chk("rd_en", {31'b0, rd}, {31'b0, exp_rd});
    @(posedge clk);
    #1;
    // reference update uses fifo_valid/dout as they were at the edge
    if (!r || fl) begin
      mq.delete();
      mbofs = 0;
      mpend = 1'b0;
    end else begin
      amt = 0;
      if (mvalid) amt = aln ? (8 - mbofs) % 8 : ((adv > 24) ? 24 : adv);
      repeat (amt) void'(mq.pop_front());
      mbofs = (mbofs + amt) % 8;
      if (gbus.fifo_valid && mpend)
        for (int i = 31; i >= 0; i--) mq.push_back(gbus.fifo_dout[i]);
      mpend = exp_rd;
    end
    chk("gb_valid", {31'b0, gbus.getbits_valid}, {31'b0, mq.size() >= 24});
    chk("getbits", {8'b0, gbus.getbits}, {8'b0, exp_gb()});
    // fifo response for the next cycle
    last_rd = rd;
    if (rd && fq.size() != 0) begin
      gbus.fifo_valid = 1'b1;
      gbus.fifo_dout  = fq.pop_front();
    end else if (stray) begin
      gbus.fifo_valid = 1'b1;
      gbus.fifo_dout  = 32'hDEADBEEF;
      stray = 1'b0;
    end else begin
      gbus.fifo_valid = 1'b0;
      gbus.fifo_dout  = '0;
    end
  endtask

  initial begin
    gbus.fifo_dout  = '0;
    gbus.fifo_valid = 1'b0;
    gbus.fifo_empty = 1'b1;
    gbus.flush      = 1'b0;
    gbus.advance    = '0;
    gbus.align      = 1'b0;

    // reset state
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // priming with no consumption, then fill=64 blocks further reads
    fq.push_back(32'h000001B3);
    fq.push_back(32'h12345678);
    for (int k = 0; k < 4; k++) step(0, 0, 0);
    chk("prime_gb", {8'b0, gbus.getbits}, 32'h000001);
    fq.push_back(32'h9ABCDEF0);
    for (int k = 0; k < 3; k++) step(0, 0, 0);

    // byte-wise consumption
    fq.push_back(32'h0F1E2D3C);
    fq.push_back(32'h4B5A6978);
    for (int k = 0; k < 10; k++) step(8, 0, 0);

    // advance 3 then align to the next byte
    step(3, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);   // already aligned: consumes nothing
    step(5, 0, 0);
    step(0, 1, 0);

    // drain with max advance, advance ignored while invalid, then refill
    for (int k = 0; k < 8; k++) step(24, 0, 0);
    step(31, 0, 0);
    fq.push_back(32'hCAFEF00D);
    fq.push_back(32'h13579BDF);
    for (int k = 0; k < 6; k++) step(24, 0, 0);
    step(30, 0, 0);  // clamps to 24

    // flush with a read in flight
    fq.push_back(32'hA5A5A5A5);
    fq.push_back(32'h5A5A5A5A);
    fq.push_back(32'h01234567);
    last_rd = 1'b0;
    for (int k = 0; k < 12 && !last_rd; k++) step(24, 0, 0);
    chk("flush_rd_seen", {31'b0, last_rd}, 32'd1);
    step(0, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 0, 0);

    // reset with a read in flight, then a stray acknowledge
    fq.push_back(32'h89ABCDEF);
    fq.push_back(32'hFEDCBA98);
    last_rd = 1'b0;
    for (int k = 0; k < 12 && !last_rd; k++) step(24, 0, 0);
    chk("reset_rd_seen", {31'b0, last_rd}, 32'd1);
    stray = 1'b1;
    step(0, 0, 0, 0);
    chk("rst_gb", {8'b0, gbus.getbits}, 32'd0);
    for (int k = 0; k < 6; k++) step(8, 0, 0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      if (fq.size() < 4 && $urandom_range(0, 9) < 4) fq.push_back($urandom());
      step($urandom_range(0, 31), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
